// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and access sequencer for the shared single-port data
// memory. Port 0 is the CPU MEM stage, port 1 is the DMA/debug loader. One
// request is granted at a time. The winner's access type, address and write
// data are latched, and the memory strobes are held for LATENCY cycles. The
// granted port then gets a one-cycle acknowledge, with read data for reads.
//
// Handshake (both ports): a requester raises req with we/addr/wdata and holds
// req high until it samples ack high at a rising edge. In the following cycle
// it drops req, unless it is issuing a new request. req/we/addr/wdata are only
// looked at in IDLE, and the winner's fields are latched on that edge. Changes
// during ACCESS or DONE have no effect.
//
// Configuration macro: DMEM_ARB_ROUND_ROBIN_EN
//   defined   : simultaneous requests go to the port not equal to grant_o
//   undefined : fixed priority, port 0 wins contention
//
// Parameters:
//   LATENCY       cycles the memory strobes are held per access (1..15)
//
// Ports:
//   clk_i         clock, all state on rising edge
//   rst_i         asynchronous active-low reset
//   p0_req_i      port 0 request, held until p0_ack_o
//   p0_we_i       port 0 access type (1 = write, 0 = read)
//   p0_addr_i     port 0 word address
//   p0_wdata_i    port 0 write data
//   p0_ack_o      port 0 one-cycle completion pulse
//   p0_rdata_o    port 0 read data, valid with ack and held afterwards
//   p1_*          same as port 0, for port 1
//   mem_read_o    memory read strobe
//   mem_write_o   memory write strobe
//   mem_addr_o    memory address (last latched value outside ACCESS)
//   mem_wdata_o   memory write data (last latched value outside ACCESS)
//   mem_rdata_i   memory read data
//   busy_o        high in any state other than IDLE
//   grant_o       index of the current or last granted port
//   state_o       debug view of the FSM state (IDLE=0, ACCESS=1, DONE=2)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    output logic        p0_ack_o,
    output logic [31:0] p0_rdata_o,

    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    output logic        p1_ack_o,
    output logic [31:0] p1_rdata_o,

    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o,
    output logic        grant_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // The counter counts down to 0 inside ACCESS, so loading LATENCY-1 gives
    // exactly LATENCY strobe cycles.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    logic        any_req;
    logic        winner;

    assign any_req = p0_req_i | p1_req_i;

    // Winner selection, only meaningful when any_req is high.
    always_comb begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (p0_req_i && p1_req_i) begin
            winner = ~grant_q;
        end else begin
            winner = p1_req_i;
        end
`else
        winner = ~p0_req_i;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    if (winner) begin
                        we_d    = p1_we_i;
                        addr_d  = p1_addr_i;
                        wdata_d = p1_wdata_i;
                    end else begin
                        we_d    = p0_we_i;
                        addr_d  = p0_addr_i;
                        wdata_d = p0_wdata_i;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Last strobe cycle: the memory read path is sampled here.
                    if (!we_q) begin
                        if (grant_q) begin
                            p1_rdata_d = mem_rdata_i;
                        end else begin
                            p0_rdata_d = mem_rdata_i;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            grant_q    <= 1'b1;   // port 0 wins the first contention
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            p0_rdata_q <= 32'd0;
            p1_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    // Strobes decode straight from the state register, so an asynchronous
    // reset drops them immediately.
    assign mem_read_o  = (state_q == ST_ACCESS) & ~we_q;
    assign mem_write_o = (state_q == ST_ACCESS) &  we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign p0_ack_o    = (state_q == ST_DONE) & ~grant_q;
    assign p1_ack_o    = (state_q == ST_DONE) &  grant_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;

    assign busy_o      = (state_q != ST_IDLE);
    assign grant_o     = grant_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int L = 2;
    localparam int N_RAND = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
    logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
    logic        mem_read, mem_write, busy, grant;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  state;

    // second instance, LATENCY = 1, port 1 unused
    logic        a_req, a_we, a_ack, b_ack;
    logic [31:0] a_addr, a_wdata, a_rdata, b_rdata;
    logic        m1_read, m1_write, m1_busy, m1_grant;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [1:0]  m1_state;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.LATENCY(L)) u_dut (
        .clk_i(clk), .rst_i(rst_n),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_ack_o(p0_ack), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_ack_o(p1_ack), .p1_rdata_o(p1_rdata),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .grant_o(grant), .state_o(state)
    );

    dmem_arbiter #(.LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .p0_req_i(a_req), .p0_we_i(a_we), .p0_addr_i(a_addr), .p0_wdata_i(a_wdata),
        .p0_ack_o(a_ack), .p0_rdata_o(a_rdata),
        .p1_req_i(1'b0), .p1_we_i(1'b0), .p1_addr_i(32'd0), .p1_wdata_i(32'd0),
        .p1_ack_o(b_ack), .p1_rdata_o(b_rdata),
        .mem_read_o(m1_read), .mem_write_o(m1_write), .mem_addr_o(m1_addr),
        .mem_wdata_o(m1_wdata), .mem_rdata_i(m1_rdata),
        .busy_o(m1_busy), .grant_o(m1_grant), .state_o(m1_state)
    );

    assign m1_rdata = 32'h5A5A_0000 | m1_addr;

    // ------------------------------------------------------------------
    // Environment data memory (16 words, indexed by addr[3:0])
    // ------------------------------------------------------------------
    logic [31:0] env_mem [16];
    logic        mem_init;

    function automatic logic [31:0] init_val(input int a);
        return 32'hC0DE_0000 | 32'(a * 17);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_val(i);
        end else if (mem_write) begin
            env_mem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    assign mem_rdata = env_mem[mem_addr[3:0]];

    // ------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        r0;  logic w0;  logic [31:0] a0;  logic [31:0] d0;
        logic        r1;  logic w1;  logic [31:0] a1;
        logic        e_rd;  logic e_wr;  logic [31:0] e_addr;
        logic        e_ack0; logic e_ack1; logic e_busy; logic e_grant;
        logic [31:0] e_rd0;  logic [31:0] e_rd1;
    } vec_t;

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1,
        input logic e_rd, input logic e_wr, input logic [31:0] e_addr,
        input logic e_ack0, input logic e_ack1, input logic e_busy, input logic e_grant,
        input logic [31:0] e_rd0, input logic [31:0] e_rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
        v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.e_busy = e_busy; v.e_grant = e_grant;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        return v;
    endfunction

    vec_t vt [18];

    // ------------------------------------------------------------------
    // Reference model state for the random phase
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [16];
    logic [31:0] exp_q [$];
    logic [31:0] exp_rd [2];
    logic [31:0] exp_maddr, exp_mwdata;
    logic        exp_grant;
    bit          cur_v;
    int          g, idle_at, cur_port;
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    bit          ack_prev [2];
    bit          pend [2];
    logic        dw [2];
    logic [31:0] da [2], dd [2];

    task automatic drive_idle();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        a_req = 0;  a_we = 0;  a_addr = 0;  a_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; mem_init = 1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1; mem_init = 0;
    endtask

    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    initial begin
        logic [31:0] tmp;
        int prob;
        bit in_acc, is_ack, e_busy;
        int wsel;

        rst_n = 0; mem_init = 1;
        drive_idle();

        // Table: write then read-back, then a mid-access input change.
        vt[0]  = mk(1,1,5,DB,  0,0,0,  0,0,0, 0,0,0,1, 0,0);
        vt[1]  = mk(1,1,5,DB,  0,0,0,  0,1,5, 0,0,1,0, 0,0);
        vt[2]  = mk(1,1,5,DB,  0,0,0,  0,1,5, 0,0,1,0, 0,0);
        vt[3]  = mk(1,1,5,DB,  0,0,0,  0,0,5, 1,0,1,0, 0,0);
        vt[4]  = mk(0,0,0,0,   1,0,5,  0,0,5, 0,0,0,0, 0,0);
        vt[5]  = mk(0,0,0,0,   1,0,5,  1,0,5, 0,0,1,1, 0,0);
        vt[6]  = mk(0,0,0,0,   1,0,5,  1,0,5, 0,0,1,1, 0,0);
        vt[7]  = mk(0,0,0,0,   1,0,5,  0,0,5, 0,1,1,1, 0,DB);
        vt[8]  = mk(0,0,0,0,   0,0,0,  0,0,5, 0,0,0,1, 0,DB);
        vt[9]  = mk(1,0,3,0,   0,0,0,  0,0,5, 0,0,0,1, 0,DB);
        vt[10] = mk(1,0,9,0,   1,0,7,  1,0,3, 0,0,1,0, 0,DB);
        vt[11] = mk(1,0,9,0,   1,0,7,  1,0,3, 0,0,1,0, 0,DB);
        vt[12] = mk(1,0,9,0,   1,0,7,  0,0,3, 1,0,1,0, 32'hC0DE_0033,DB);
        vt[13] = mk(0,0,0,0,   1,0,7,  0,0,3, 0,0,0,0, 32'hC0DE_0033,DB);
        vt[14] = mk(0,0,0,0,   1,0,7,  1,0,7, 0,0,1,1, 32'hC0DE_0033,DB);
        vt[15] = mk(0,0,0,0,   1,0,7,  1,0,7, 0,0,1,1, 32'hC0DE_0033,DB);
        vt[16] = mk(0,0,0,0,   1,0,7,  0,0,7, 0,1,1,1, 32'hC0DE_0033,32'hC0DE_0077);
        vt[17] = mk(0,0,0,0,   0,0,0,  0,0,7, 0,0,0,1, 32'hC0DE_0033,32'hC0DE_0077);

        // ---------------- reset values ----------------
        @(negedge clk);
        @(negedge clk);
        chk1 ("rst_busy",  busy, 1'b0);
        chk1 ("rst_grant", grant, 1'b1);
        chk1 ("rst_rd",    mem_read, 1'b0);
        chk1 ("rst_wr",    mem_write, 1'b0);
        chk1 ("rst_ack0",  p0_ack, 1'b0);
        chk1 ("rst_ack1",  p1_ack, 1'b0);
        chk32("rst_maddr", mem_addr, 32'd0);
        chk32("rst_mwdata", mem_wdata, 32'd0);
        chk32("rst_rdata0", p0_rdata, 32'd0);
        chk32("rst_rdata1", p1_rdata, 32'd0);
        rst_n = 1; mem_init = 0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            p0_req = vt[i].r0; p0_we = vt[i].w0; p0_addr = vt[i].a0; p0_wdata = vt[i].d0;
            p1_req = vt[i].r1; p1_we = vt[i].w1; p1_addr = vt[i].a1; p1_wdata = 32'd0;
            chk1 ("tbl_rd",    mem_read,  vt[i].e_rd);
            chk1 ("tbl_wr",    mem_write, vt[i].e_wr);
            chk32("tbl_maddr", mem_addr,  vt[i].e_addr);
            chk1 ("tbl_ack0",  p0_ack,    vt[i].e_ack0);
            chk1 ("tbl_ack1",  p1_ack,    vt[i].e_ack1);
            chk1 ("tbl_busy",  busy,      vt[i].e_busy);
            chk1 ("tbl_grant", grant,     vt[i].e_grant);
            chk32("tbl_rdata0", p0_rdata, vt[i].e_rd0);
            chk32("tbl_rdata1", p1_rdata, vt[i].e_rd1);
            if (i == 2) chk32("tbl_mwdata", mem_wdata, DB);
        end

        // ---------------- reset during the second ACCESS cycle of a write ----------------
        @(negedge clk);
        p0_req = 1; p0_we = 1; p0_addr = 12; p0_wdata = 32'h1234_5678;
        @(negedge clk);
        chk1("rw_wr_c1", mem_write, 1'b1);
        @(negedge clk);
        chk1("rw_wr_c2", mem_write, 1'b1);
        rst_n = 0;
        #1;
        chk1("rw_async_wr",   mem_write, 1'b0);
        chk1("rw_async_rd",   mem_read, 1'b0);
        chk1("rw_async_busy", busy, 1'b0);
        p0_req = 0;
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1 ("rw_ack0",  p0_ack, 1'b0);
            chk1 ("rw_ack1",  p1_ack, 1'b0);
            chk1 ("rw_busy",  busy, 1'b0);
            chk1 ("rw_grant", grant, 1'b1);
            chk32("rw_rdata0", p0_rdata, 32'd0);
        end

        // ---------------- LATENCY = 1 single read ----------------
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 2; a_wdata = 0;
        chk1("l1_busy_t0", m1_busy, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) a_req = 0;
            chk1("l1_busy",  m1_busy, (k == 1 || k == 2));
            chk1("l1_rd",    m1_read, (k == 1));
            chk1("l1_wr",    m1_write, 1'b0);
            chk1("l1_ack",   a_ack, (k == 2));
            chk1("l1_ack_b", b_ack, 1'b0);
            chk1("l1_grant", m1_grant, 1'b0);
            if (k >= 2) chk32("l1_rdata", a_rdata, 32'h5A5A_0002);
        end
        chk32("l1_maddr",  m1_addr, 32'd2);
        chk32("l1_mwdata", m1_wdata, 32'd0);
        chk32("l1_rdata_b", b_rdata, 32'd0);

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        exp_q.delete();
        exp_rd[0] = 0; exp_rd[1] = 0;
        exp_maddr = 0; exp_mwdata = 0; exp_grant = 1;
        cur_v = 0; g = 0; idle_at = 0; cur_port = 0;
        cur_we = 0; cur_addr = 0; cur_wdata = 0;
        for (int p = 0; p < 2; p++) begin
            ack_prev[p] = 0; pend[p] = 0; dw[p] = 0; da[p] = 0; dd[p] = 0;
        end

        for (int c = 0; c < N_RAND; c++) begin
            @(negedge clk);
            prob = (c < 200) ? 100 : 40;

            // requesters
            for (int p = 0; p < 2; p++) begin
                if (ack_prev[p]) begin
                    pend[p] = 0;
                end else if (!pend[p]) begin
                    if ($urandom_range(0, 99) < prob) begin
                        pend[p] = 1;
                        dw[p]   = 1'($urandom_range(0, 1));
                        tmp     = $urandom();
                        da[p]   = tmp & 32'hF000_000F;
                        dd[p]   = $urandom();
                    end
                end else if (cur_v && cur_port == p && c > g) begin
                    // already latched by the arbiter: these must be ignored
                    dw[p] = 1'($urandom_range(0, 1));
                    da[p] = $urandom();
                    dd[p] = $urandom();
                end
            end
            p0_req = pend[0]; p0_we = dw[0]; p0_addr = da[0]; p0_wdata = dd[0];
            p1_req = pend[1]; p1_we = dw[1]; p1_addr = da[1]; p1_wdata = dd[1];

            // expected outputs for this cycle
            in_acc = cur_v && (c >= g + 1) && (c <= g + L);
            is_ack = cur_v && (c == g + L + 1);
            e_busy = cur_v && (c >= g + 1) && (c <= g + L + 1);
            if (is_ack) begin
                if (!cur_we) begin
                    if (exp_q.size() > 0) exp_rd[cur_port] = exp_q.pop_front();
                end else begin
                    ref_mem[cur_addr[3:0]] = cur_wdata;
                end
            end

            chk1 ("rnd_rd",     mem_read,  in_acc && !cur_we);
            chk1 ("rnd_wr",     mem_write, in_acc && cur_we);
            chk1 ("rnd_ack0",   p0_ack,    is_ack && cur_port == 0);
            chk1 ("rnd_ack1",   p1_ack,    is_ack && cur_port == 1);
            chk1 ("rnd_busy",   busy,      e_busy);
            chk1 ("rnd_idle_st", (state == 2'd0), !e_busy);
            chk1 ("rnd_grant",  grant,     exp_grant);
            chk32("rnd_maddr",  mem_addr,  exp_maddr);
            chk32("rnd_mwdata", mem_wdata, exp_mwdata);
            chk32("rnd_rdata0", p0_rdata,  exp_rd[0]);
            chk32("rnd_rdata1", p1_rdata,  exp_rd[1]);

            ack_prev[0] = is_ack && cur_port == 0;
            ack_prev[1] = is_ack && cur_port == 1;

            // arbitration decision taken at the end of an IDLE cycle
            if (c >= idle_at && (pend[0] || pend[1])) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (pend[0] && pend[1]) wsel = exp_grant ? 0 : 1;
                else                    wsel = pend[1] ? 1 : 0;
`else
                wsel = pend[0] ? 0 : 1;
`endif
                cur_v     = 1;
                g         = c;
                cur_port  = wsel;
                cur_we    = dw[wsel];
                cur_addr  = da[wsel];
                cur_wdata = dd[wsel];
                exp_grant = 1'(wsel);
                exp_maddr = da[wsel];
                exp_mwdata = dd[wsel];
                idle_at   = c + L + 2;
                if (!cur_we) exp_q.push_back(ref_mem[cur_addr[3:0]]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the shared single-port data memory. It accepts word read/write requests from port 0 (CPU MEM stage) and port 1 (DMA/debug loader). It grants one request at a time, drives the memory's read/write strobes, address and write data for a fixed number of cycles, then returns an acknowledge and read data to the granted port. It sits between the pipeline's MEM stage and DataMemory and exports `busy_o` for the hazard/stall logic.

## Interface
- `LATENCY`, 2: cycles the memory strobes are held per access; legal range 1..15.
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `p0_req_i` in 1: port 0 request; held high until `p0_ack_o`.
- `p0_we_i` in 1: port 0 access type; 1 = write, 0 = read.
- `p0_addr_i` in 32: port 0 word address.
- `p0_wdata_i` in 32: port 0 write data.
- `p0_ack_o` out 1: one-cycle completion pulse for port 0.
- `p0_rdata_o` out 32: port 0 read data; valid with the ack, then held.
- `p1_req_i`, `p1_we_i`, `p1_addr_i`, `p1_wdata_i`, `p1_ack_o`, `p1_rdata_o`: same as port 0, for port 1.
- `mem_read_o` out 1: memory read strobe.
- `mem_write_o` out 1: memory write strobe.
- `mem_addr_o` out 32: memory address.
- `mem_wdata_o` out 32: memory write data.
- `mem_rdata_i` in 32: memory read data.
- `busy_o` out 1: high in any state other than IDLE.
- `grant_o` out 1: index of the current or last granted port.

## Operation
- There are three states: IDLE, ACCESS and DONE.
- **IDLE**
  - If any request is high, the arbiter picks a winner.
  - On the clock edge it latches the winner's `we`, `addr` and `wdata` into internal registers and records the winner in `grant_o`.
  - It then loads the counter with `LATENCY-1` and moves to ACCESS.
  - With no request it stays in IDLE.
- **ACCESS**
  - `mem_addr_o` and `mem_wdata_o` come from the latched registers.
  - `mem_write_o` equals the latched `we`; `mem_read_o` equals its inverse. Exactly one strobe is high.
  - The counter decrements each cycle.
  - When the counter is 0, a latched read captures `mem_rdata_i` into the granted port's rdata register on that edge, and the state moves to DONE.
- **DONE**
  - The granted port's ack is high for exactly this cycle.
  - Both strobes are low.
  - The next state is always IDLE.
- Requester rule:
  - A requester samples its ack at the edge ending DONE.
  - It must drive req low in the following cycle unless it is issuing a new request.
  - Request inputs are ignored outside IDLE; changing them mid-access has no effect.
- Write completion: a write's ack leaves that port's `rdata_o` unchanged.
- Outside ACCESS, `mem_addr_o` and `mem_wdata_o` hold their last latched value. They are 0 after reset.
- Reset values:
  - State IDLE, counter 0.
  - All strobes 0, acks 0, `busy_o` 0.
  - `p0_rdata_o` and `p1_rdata_o` are 0, `mem_addr_o` and `mem_wdata_o` are 0.
  - `grant_o` is 1, so port 0 wins the first contention.
- Reset mid-access: strobes drop immediately (asynchronous). No ack is issued and the interrupted access is not retried.

## Timing
- A request seen high in IDLE at cycle t gets:
  - strobes during cycles t+1 .. t+LATENCY;
  - ack at cycle t+LATENCY+1.
- Back-to-back: a new request is accepted no earlier than the IDLE cycle that follows DONE. The throughput is one access per LATENCY+2 cycles.
- Read data is the memory value sampled at the edge ending the last ACCESS cycle. DataMemory's read path must be valid by then.
- `busy_o` is high from t+1 through t+LATENCY+1 inclusive.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests in IDLE, the port not equal to `grant_o` wins.
  - A single request always wins, regardless of `grant_o`.
- `DMEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: port 0 always wins contention.
  - `grant_o` still reports the winner.

## Test plan
- Reset, then port 0 writes `0xDEADBEEF` to addr 5 with LATENCY=2:
  - `mem_write_o` is high for 2 cycles with addr 5;
  - `p0_ack_o` pulses at t+3;
  - `p0_rdata_o` stays 0.
- Port 1 reads addr 5 after that write:
  - `mem_read_o` is high for 2 cycles;
  - `p1_ack_o` is high at t+3 with `p1_rdata_o = 0xDEADBEEF`;
  - `p0_rdata_o` is unchanged.
- Both ports request continuously, each deasserting for one cycle after its ack:
  - with the macro, grants alternate 0,1,0,1;
  - without the macro, port 0 is granted every time it requests and port 1 is served only when port 0 is idle.
- During ACCESS, port 1 raises req and port 0 changes addr to 9:
  - the memory address stays at the latched value;
  - port 1 is granted in the IDLE cycle after DONE.
- Assert `rst_i` low during the second ACCESS cycle of a write:
  - strobes go low asynchronously and no ack is issued;
  - after release the block is in IDLE with `busy_o` 0 and `grant_o` 1.
- LATENCY=1, a single read:
  - ack at t+2;
  - `busy_o` is high for exactly 2 cycles.
